// File: rtl/beta_trap_csr_file_if.sv
// Zicsr access bus between the CSR-instruction issuer and the trap CSR bank.
// The bank answers combinationally with the old value and an access-fault flag.
interface beta_trap_csr_file_if;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;

    modport master (
        output csr_addr_i,
        output csr_op_i,
        output csr_wdata_i,
        input  csr_rdata_o,
        input  csr_illegal_o
    );

    modport slave (
        input  csr_addr_i,
        input  csr_op_i,
        input  csr_wdata_i,
        output csr_rdata_o,
        output csr_illegal_o
    );
endinterface

// File: rtl/beta_trap_csr_file.sv
// Machine-mode trap CSR bank: Zicsr access, trap-entry/MRET updates,
// privilege level and the 64-bit mcycle/minstret counters.
module beta_trap_csr_file #(
    parameter int unsigned DataWidth   = 32,
    parameter logic [31:0] BootTrapVec = 32'h0000_0000,
    parameter logic [31:0] MisaValue   = 32'h4000_0100,
    parameter logic [31:0] HartId      = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    beta_trap_csr_file_if.slave csr,
    input  logic        tcu_csr_we_i,
    input  logic        tcu_mret_i,
    input  logic [31:0] tcu_mepc_i,
    input  logic [31:0] tcu_mcause_i,
    input  logic [31:0] tcu_mtval_i,
    input  logic [2:0]  tcu_trap_state_i,
    input  logic        tcu_ext_int_pend_i,
    input  logic        tcu_tim_int_pend_i,
    input  logic        tcu_sw_int_pend_i,
    input  logic        instr_retired_i,
    output logic        priv_lvl_o,
    output logic        mie_o,
    output logic        mpie_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtvec_o,
    output logic [1:0]  ext_int_o,
    output logic [1:0]  tim_int_o,
    output logic [1:0]  soft_int_o
);

    localparam logic [11:0] AMstatus  = 12'h300;
    localparam logic [11:0] AMisa     = 12'h301;
    localparam logic [11:0] AMie      = 12'h304;
    localparam logic [11:0] AMtvec    = 12'h305;
    localparam logic [11:0] AMscratch = 12'h340;
    localparam logic [11:0] AMepc     = 12'h341;
    localparam logic [11:0] AMcause   = 12'h342;
    localparam logic [11:0] AMtval    = 12'h343;
    localparam logic [11:0] AMip      = 12'h344;
    localparam logic [11:0] AMcycle   = 12'hB00;
    localparam logic [11:0] AMinstret = 12'hB02;
    localparam logic [11:0] AMcycleh  = 12'hB80;
    localparam logic [11:0] AMinstrh  = 12'hB82;
    localparam logic [11:0] AMhartid  = 12'hF14;

    logic                 priv;
    logic                 st_mie;
    logic                 st_mpie;
    logic                 st_mpp;
    logic                 meie;
    logic                 mtie;
    logic                 msie;
    logic                 meip;
    logic                 mtip;
    logic                 msip;
    logic [DataWidth-1:0] mtvec;
    logic [DataWidth-1:0] mscratch;
    logic [DataWidth-1:0] mepc;
    logic [DataWidth-1:0] mcause;
    logic [DataWidth-1:0] mtval;
    logic [63:0]          mcycle;
    logic [63:0]          minstret;
    logic [63:0]          mcycle_nxt;
    logic [63:0]          minstret_nxt;

    logic                 mapped;
    logic [DataWidth-1:0] rd_val;
    logic [DataWidth-1:0] wr_val;
    logic                 illegal;
    logic                 wr_en;
    logic                 own_ok;
    logic                 trap_entry;
    logic                 trap_mret;

    always_comb begin
        mapped = 1'b1;
        rd_val = '0;
        unique case (csr.csr_addr_i)
            AMstatus:  rd_val = {19'd0, {2{st_mpp}}, 3'd0, st_mpie,
                                 3'd0, st_mie, 3'd0};
            AMisa:     rd_val = MisaValue;
            AMie:      rd_val = {20'd0, meie, 3'd0, mtie, 3'd0, msie, 3'd0};
            AMtvec:    rd_val = mtvec;
            AMscratch: rd_val = mscratch;
            AMepc:     rd_val = mepc;
            AMcause:   rd_val = mcause;
            AMtval:    rd_val = mtval;
            AMip:      rd_val = {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0};
            AMcycle:   rd_val = mcycle[31:0];
            AMcycleh:  rd_val = mcycle[63:32];
            AMinstret: rd_val = minstret[31:0];
            AMinstrh:  rd_val = minstret[63:32];
            AMhartid:  rd_val = HartId;
            default:   mapped = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (csr.csr_op_i != 2'b00) begin
            illegal = !mapped || !priv || (csr.csr_addr_i[11:10] == 2'b11);
        end
        wr_en = (csr.csr_op_i != 2'b00) && !illegal;
        unique case (csr.csr_op_i)
            2'b10:   wr_val = rd_val | csr.csr_wdata_i;
            2'b11:   wr_val = rd_val & ~csr.csr_wdata_i;
            default: wr_val = csr.csr_wdata_i;
        endcase
    end

    assign csr.csr_rdata_o   = rd_val;
    assign csr.csr_illegal_o = illegal;

    // Trap-owned CSRs lose any same-cycle instruction write to the TCU.
    assign own_ok     = wr_en && !tcu_csr_we_i;
    assign trap_entry = tcu_csr_we_i && !tcu_mret_i;
    assign trap_mret  = tcu_csr_we_i && tcu_mret_i;

    always_comb begin
        mcycle_nxt   = mcycle + 64'd1;
        minstret_nxt = minstret + {63'd0, instr_retired_i};
        if (wr_en) begin
            unique case (csr.csr_addr_i)
                AMcycle:   mcycle_nxt   = {mcycle[63:32], wr_val};
                AMcycleh:  mcycle_nxt   = {wr_val, mcycle[31:0]};
                AMinstret: minstret_nxt = {minstret[63:32], wr_val};
                AMinstrh:  minstret_nxt = {wr_val, minstret[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            priv     <= 1'b1;
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            st_mpp   <= 1'b1;
            meie     <= 1'b0;
            mtie     <= 1'b0;
            msie     <= 1'b0;
            meip     <= 1'b0;
            mtip     <= 1'b0;
            msip     <= 1'b0;
            mtvec    <= BootTrapVec;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle_nxt;
            minstret <= minstret_nxt;
            if (wr_en) begin
                unique case (csr.csr_addr_i)
                    AMie: begin
                        meie <= wr_val[11];
                        mtie <= wr_val[7];
                        msie <= wr_val[3];
                    end
                    AMtvec:    mtvec    <= wr_val & ~32'h2;
                    AMscratch: mscratch <= wr_val;
                    default: ;
                endcase
            end
            if (own_ok) begin
                unique case (csr.csr_addr_i)
                    AMstatus: begin
                        st_mie  <= wr_val[3];
                        st_mpie <= wr_val[7];
                        st_mpp  <= |wr_val[12:11];
                    end
                    AMepc:   mepc   <= wr_val & ~32'h3;
                    AMcause: mcause <= wr_val;
                    AMtval:  mtval  <= wr_val;
                    AMip: begin
                        meip <= wr_val[11];
                        mtip <= wr_val[7];
                        msip <= wr_val[3];
                    end
                    default: ;
                endcase
            end
            if (trap_entry) begin
                mepc    <= tcu_mepc_i & ~32'h3;
                mcause  <= tcu_mcause_i;
                mtval   <= tcu_mtval_i;
                st_mie  <= tcu_trap_state_i[2];
                st_mpie <= tcu_trap_state_i[1];
                st_mpp  <= tcu_trap_state_i[0];
                priv    <= 1'b1;
                meip    <= meip | tcu_ext_int_pend_i;
                mtip    <= mtip | tcu_tim_int_pend_i;
                msip    <= msip | tcu_sw_int_pend_i;
            end
            if (trap_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                priv    <= st_mpp;
                st_mpp  <= 1'b0;
            end
        end
    end

    assign priv_lvl_o = priv;
    assign mie_o      = st_mie;
    assign mpie_o     = st_mpie;
    assign mepc_o     = mepc;
    assign mtvec_o    = mtvec;
    assign ext_int_o  = {meip, meie};
    assign tim_int_o  = {mtip, mtie};
    assign soft_int_o = {msip, msie};

endmodule

// File: tb/tb_beta_trap_csr_file.sv
// Bench for beta_trap_csr_file: directed vector table, counter/reset
// sequences and random traffic against a word-level reference model.
module tb_beta_trap_csr_file;

    localparam logic [31:0] TbVec  = 32'h8000_0100;
    localparam logic [31:0] TbMisa = 32'h4000_0100;
    localparam logic [31:0] TbHart = 32'h0000_0005;

    typedef struct packed {
        logic        rst;
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wd;
        logic        twe;
        logic        tmret;
        logic [31:0] tepc;
        logic [31:0] tcause;
        logic [31:0] tval;
        logic [2:0]  tst;
        logic [2:0]  pend;
        logic        ret;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] er;
        logic        ei;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        tcu_csr_we_i, tcu_mret_i;
    logic [31:0] tcu_mepc_i, tcu_mcause_i, tcu_mtval_i;
    logic [2:0]  tcu_trap_state_i;
    logic        tcu_ext_int_pend_i, tcu_tim_int_pend_i, tcu_sw_int_pend_i;
    logic        instr_retired_i;
    logic        priv_lvl_o, mie_o, mpie_o;
    logic [31:0] mepc_o, mtvec_o;
    logic [1:0]  ext_int_o, tim_int_o, soft_int_o;

    int n_cmp = 0;
    int n_bad = 0;

    beta_trap_csr_file_if bus ();

    beta_trap_csr_file #(
        .DataWidth   (32),
        .BootTrapVec (TbVec),
        .MisaValue   (TbMisa),
        .HartId      (TbHart)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .csr                (bus),
        .tcu_csr_we_i       (tcu_csr_we_i),
        .tcu_mret_i         (tcu_mret_i),
        .tcu_mepc_i         (tcu_mepc_i),
        .tcu_mcause_i       (tcu_mcause_i),
        .tcu_mtval_i        (tcu_mtval_i),
        .tcu_trap_state_i   (tcu_trap_state_i),
        .tcu_ext_int_pend_i (tcu_ext_int_pend_i),
        .tcu_tim_int_pend_i (tcu_tim_int_pend_i),
        .tcu_sw_int_pend_i  (tcu_sw_int_pend_i),
        .instr_retired_i    (instr_retired_i),
        .priv_lvl_o         (priv_lvl_o),
        .mie_o              (mie_o),
        .mpie_o             (mpie_o),
        .mepc_o             (mepc_o),
        .mtvec_o            (mtvec_o),
        .ext_int_o          (ext_int_o),
        .tim_int_o          (tim_int_o),
        .soft_int_o         (soft_int_o)
    );

    always #5 clk = ~clk;

    // Reference model: every CSR held as its architectural 32-bit word.
    bit [31:0] m_status, m_ie, m_tvec, m_scratch;
    bit [31:0] m_epc, m_cause, m_tval, m_ip;
    bit [63:0] m_cyc, m_ins;
    bit        m_priv;

    function automatic bit m_mapped(logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
            12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
            12'hB82, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        case (a)
            12'h300: return m_status;
            12'h301: return TbMisa;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF14: return TbHart;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal(logic [11:0] a, logic [1:0] op);
        if (op == 2'b00) return 1'b0;
        return !m_mapped(a) || !m_priv || (a >= 12'hC00);
    endfunction

    task automatic m_step(stim_t s);
        bit [31:0] old, nv;
        bit wr, cw, iw;
        if (s.rst) begin
            m_status = 32'h1800; m_ie = 0; m_tvec = TbVec; m_scratch = 0;
            m_epc = 0; m_cause = 0; m_tval = 0; m_ip = 0;
            m_cyc = 0; m_ins = 0; m_priv = 1;
            return;
        end
        old = m_read(s.addr);
        wr = (s.op != 2'b00) && !m_illegal(s.addr, s.op);
        nv = (s.op == 2'b01) ? s.wd :
             (s.op == 2'b10) ? (old | s.wd) : (old & ~s.wd);
        cw = 0; iw = 0;
        if (wr) begin
            case (s.addr)
                12'h300: if (!s.twe)
                    m_status = (nv & 32'h88) |
                               ((nv[12:11] != 0) ? 32'h1800 : 32'h0);
                12'h304: m_ie = nv & 32'h888;
                12'h305: m_tvec = nv & 32'hFFFF_FFFD;
                12'h340: m_scratch = nv;
                12'h341: if (!s.twe) m_epc = nv & 32'hFFFF_FFFC;
                12'h342: if (!s.twe) m_cause = nv;
                12'h343: if (!s.twe) m_tval = nv;
                12'h344: if (!s.twe) m_ip = nv & 32'h888;
                12'hB00: begin m_cyc[31:0] = nv; cw = 1; end
                12'hB80: begin m_cyc[63:32] = nv; cw = 1; end
                12'hB02: begin m_ins[31:0] = nv; iw = 1; end
                12'hB82: begin m_ins[63:32] = nv; iw = 1; end
                default: ;
            endcase
        end
        if (!cw) m_cyc = m_cyc + 1;
        if (!iw && s.ret) m_ins = m_ins + 1;
        if (s.twe && !s.tmret) begin
            m_epc = s.tepc & 32'hFFFF_FFFC;
            m_cause = s.tcause;
            m_tval = s.tval;
            m_status = (s.tst[2] ? 32'h8 : 0) | (s.tst[1] ? 32'h80 : 0) |
                       (s.tst[0] ? 32'h1800 : 0);
            m_priv = 1;
            m_ip = m_ip | (s.pend[2] ? 32'h800 : 0) |
                   (s.pend[1] ? 32'h80 : 0) | (s.pend[0] ? 32'h8 : 0);
        end
        if (s.twe && s.tmret) begin
            m_priv = (m_status[12:11] != 0);
            m_status = (m_status[7] ? 32'h8 : 0) | 32'h80;
        end
    endtask

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic apply(stim_t s, bit xp, logic [31:0] er, logic ei);
        @(negedge clk);
        rst_i = s.rst;
        bus.csr_addr_i = s.addr;
        bus.csr_op_i = s.op;
        bus.csr_wdata_i = s.wd;
        tcu_csr_we_i = s.twe;
        tcu_mret_i = s.tmret;
        tcu_mepc_i = s.tepc;
        tcu_mcause_i = s.tcause;
        tcu_mtval_i = s.tval;
        tcu_trap_state_i = s.tst;
        tcu_ext_int_pend_i = s.pend[2];
        tcu_tim_int_pend_i = s.pend[1];
        tcu_sw_int_pend_i = s.pend[0];
        instr_retired_i = s.ret;
        #1;
        if (!s.rst) begin
            chk("rdata", bus.csr_rdata_o, m_read(s.addr));
            chk("illegal", bus.csr_illegal_o, m_illegal(s.addr, s.op));
        end
        if (xp) begin
            chk($sformatf("vec_rdata@%h", s.addr), bus.csr_rdata_o, er);
            chk($sformatf("vec_illegal@%h", s.addr), bus.csr_illegal_o, ei);
        end
        @(posedge clk);
        m_step(s);
        #1;
        chk("priv_lvl", priv_lvl_o, m_priv);
        chk("mie", mie_o, m_status[3]);
        chk("mpie", mpie_o, m_status[7]);
        chk("mepc", mepc_o, m_epc);
        chk("mtvec", mtvec_o, m_tvec);
        chk("ext_int", ext_int_o, {m_ip[11], m_ie[11]});
        chk("tim_int", tim_int_o, {m_ip[7], m_ie[7]});
        chk("soft_int", soft_int_o, {m_ip[3], m_ie[3]});
    endtask

    function automatic stim_t mk(logic [11:0] a, logic [1:0] o,
                                 logic [31:0] w);
        stim_t s;
        s = '0;
        s.addr = a; s.op = o; s.wd = w;
        return s;
    endfunction

    function automatic stim_t tr(stim_t s0, logic m, logic [31:0] e,
                                 logic [31:0] c, logic [31:0] v,
                                 logic [2:0] t, logic [2:0] p);
        stim_t s;
        s = s0;
        s.twe = 1; s.tmret = m; s.tepc = e; s.tcause = c;
        s.tval = v; s.tst = t; s.pend = p;
        return s;
    endfunction

    vec_t tbl[$];

    task automatic add(stim_t s, logic [31:0] er, logic ei);
        vec_t v;
        v.s = s; v.er = er; v.ei = ei;
        tbl.push_back(v);
    endtask

    initial begin
        stim_t s;
        logic [11:0] alist [16];
        alist = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                  12'hB82, 12'hF14, 12'h7C0, 12'hC00};

        add(mk(12'h300, 2'b00, 0), 32'h0000_1800, 0);
        add(mk(12'h305, 2'b00, 0), TbVec, 0);
        add(mk(12'hF14, 2'b01, 0), TbHart, 1);
        add(mk(12'h301, 2'b00, 0), TbMisa, 0);
        add(mk(12'h301, 2'b01, 32'hFFFF_FFFF), TbMisa, 0);
        add(mk(12'h305, 2'b01, 32'hFFFF_FFFF), TbVec, 0);
        add(mk(12'h305, 2'b00, 0), 32'hFFFF_FFFD, 0);
        add(mk(12'h344, 2'b10, 32'h888), 32'h0, 0);
        add(mk(12'h344, 2'b11, 32'h008), 32'h888, 0);
        add(mk(12'h344, 2'b11, 32'h880), 32'h880, 0);
        add(mk(12'h7C0, 2'b00, 0), 32'h0, 0);
        add(mk(12'h7C0, 2'b10, 32'h1), 32'h0, 1);
        add(tr(mk(12'h340, 2'b01, 32'h55), 0, 32'h102, 32'h8000_000B,
               0, 3'b011, 3'b100), 32'h0, 0);
        add(mk(12'h341, 2'b00, 0), 32'h100, 0);
        add(mk(12'h342, 2'b00, 0), 32'h8000_000B, 0);
        add(mk(12'h300, 2'b00, 0), 32'h0000_1880, 0);
        add(mk(12'h340, 2'b00, 0), 32'h55, 0);
        add(mk(12'h344, 2'b00, 0), 32'h800, 0);
        add(tr(mk(12'h341, 2'b01, 32'h200), 0, 32'h300, 32'h2,
               32'hDEAD, 3'b010, 3'b000), 32'h100, 0);
        add(mk(12'h341, 2'b00, 0), 32'h300, 0);
        add(mk(12'h300, 2'b00, 0), 32'h80, 0);
        add(tr(mk(12'h300, 2'b00, 0), 1, 0, 0, 0, 0, 0), 32'h80, 0);
        add(mk(12'h300, 2'b00, 0), 32'h88, 0);
        add(mk(12'h300, 2'b01, 0), 32'h88, 1);
        add(mk(12'h300, 2'b00, 0), 32'h88, 0);
        add(mk(12'h340, 2'b00, 0), 32'h55, 0);
        add(tr(mk(12'h300, 2'b00, 0), 0, 32'h44, 32'h3, 0,
               3'b100, 3'b111), 32'h88, 0);
        add(mk(12'h344, 2'b00, 0), 32'h888, 0);
        add(mk(12'h300, 2'b00, 0), 32'h8, 0);
        add(mk(12'h304, 2'b01, 32'hFFFF_FFFF), 32'h0, 0);
        add(mk(12'h304, 2'b00, 0), 32'h888, 0);

        s = mk(12'h300, 2'b00, 0);
        s.rst = 1;
        apply(s, 0, 0, 0);
        apply(s, 0, 0, 0);
        foreach (tbl[i]) apply(tbl[i].s, 1, tbl[i].er, tbl[i].ei);

        // Counter carry and wrap.
        apply(mk(12'hB00, 2'b01, 32'hFFFF_FFFF), 0, 0, 0);
        apply(mk(12'hB80, 2'b01, 32'h0), 0, 0, 0);
        apply(mk(12'hB80, 2'b00, 0), 1, 32'h0, 0);
        apply(mk(12'hB00, 2'b00, 0), 1, 32'h0, 0);
        apply(mk(12'hB80, 2'b00, 0), 1, 32'h1, 0);
        apply(mk(12'hB02, 2'b01, 32'h0), 0, 0, 0);
        apply(mk(12'hB82, 2'b01, 32'h0), 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            s = mk(12'hB02, 2'b00, 0);
            s.ret = (i != 1) && (i != 4);
            apply(s, 0, 0, 0);
        end
        apply(mk(12'hB02, 2'b00, 0), 1, 32'h3, 0);
        apply(mk(12'hB02, 2'b01, 32'hFFFF_FFFF), 0, 0, 0);
        apply(mk(12'hB82, 2'b01, 32'hFFFF_FFFF), 0, 0, 0);
        s = mk(12'hB82, 2'b00, 0);
        s.ret = 1;
        apply(s, 1, 32'hFFFF_FFFF, 0);
        apply(mk(12'hB02, 2'b00, 0), 1, 32'h0, 0);
        apply(mk(12'hB82, 2'b00, 0), 1, 32'h0, 0);

        // Reset landing on top of a trap and a write, then free-running.
        s = tr(mk(12'h305, 2'b01, 32'h1234), 0, 32'h88, 32'h7, 32'h9,
               3'b111, 3'b111);
        s.rst = 1;
        apply(s, 0, 0, 0);
        s = mk(12'h300, 2'b00, 0);
        s.rst = 1;
        apply(s, 0, 0, 0);
        for (int i = 0; i < 10; i++) apply(mk(12'hB00, 2'b00, 0), 0, 0, 0);
        apply(mk(12'hB00, 2'b00, 0), 1, 32'd10, 0);
        apply(mk(12'h300, 2'b00, 0), 1, 32'h0000_1800, 0);
        apply(mk(12'h305, 2'b00, 0), 1, TbVec, 0);
        apply(mk(12'h341, 2'b00, 0), 1, 32'h0, 0);

        for (int i = 0; i < 600; i++) begin
            s = mk(alist[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
                   $urandom);
            if ($urandom_range(0, 4) == 0)
                s = tr(s, 1'($urandom_range(0, 1)), $urandom, $urandom,
                       $urandom, 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)));
            s.ret = 1'($urandom_range(0, 1));
            s.rst = ($urandom_range(0, 150) == 0);
            apply(s, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
